// File: rtl/l2_mm_write_buffer.sv
// l2_mm_write_buffer: posted-write FIFO between the L2 main-memory port and main_memory.
// Absorbs L2 write-backs, drains them to memory in the background, coalesces
// rewrites of a buffered address and forwards L2 reads from the buffer on a hit.
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   L2_read_request / L2_write_request / L2_word_address / L2_wdata   L2 request side
//   L2_rdata, MM_busy          registered read data and busy back to L2
//   mm_read_request / mm_write_request / mm_word_address / mm_wdata   memory request side
//   mm_rdata, mm_busy          read data and busy from main_memory
//   buf_empty                  no buffered entries and no drain in flight
module l2_mm_write_buffer #(
  parameter int unsigned n      = 32,
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              L2_read_request,
  input  logic              L2_write_request,
  input  logic [ADDR_W-1:0] L2_word_address,
  input  logic [n-1:0]      L2_wdata,
  output logic [n-1:0]      L2_rdata,
  output logic              MM_busy,
  output logic              mm_read_request,
  output logic              mm_write_request,
  output logic [ADDR_W-1:0] mm_word_address,
  output logic [n-1:0]      mm_wdata,
  input  logic [n-1:0]      mm_rdata,
  input  logic              mm_busy,
  output logic              buf_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_ACK, RD_DONE, WR_ISSUE, WR_ACK, WR_DONE
  } state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_addr [DEPTH];
  logic [n-1:0]       r_data [DEPTH];
  logic [PTR_W-1:0]   r_head, r_tail;
  logic [CNT_W-1:0]   r_count;
  logic               r_wr_pend, r_rd_pend, r_hit;
  logic [ADDR_W-1:0]  r_pend_addr;
  logic [n-1:0]       r_pend_data, r_hit_data, r_l2_rdata, r_mm_wdata;
  logic [ADDR_W-1:0]  r_mm_addr;
  logic               r_mm_busy_o, r_mm_rd_req, r_mm_wr_req;

  logic               w_in_wr, w_launch_wr, w_launch_rd, w_hd_busy, w_deq;
  logic               w_wr_acc, w_rd_acc, w_full, w_enq_new, w_enq_pend, w_enq;
  logic               w_rd_hit, w_co_hit;
  logic [n-1:0]       w_rd_data, w_enq_data;
  logic [ADDR_W-1:0]  w_enq_addr;
  logic [PTR_W-1:0]   w_co_idx;

  // Control decode: drain launch, acceptance and enqueue/dequeue strobes
  always_comb begin
    w_in_wr     = (r_state == WR_ISSUE) || (r_state == WR_ACK) || (r_state == WR_DONE);
    w_launch_rd = (r_state == IDLE) && r_rd_pend && !mm_busy;
    w_launch_wr = (r_state == IDLE) && !r_rd_pend && (r_count != '0) && !mm_busy;
    // Head is frozen once its drain starts (including the launch edge itself)
    w_hd_busy   = w_in_wr || w_launch_wr;
    w_deq       = (r_state == WR_DONE) && !mm_busy;
    w_wr_acc    = !r_mm_busy_o && L2_write_request;
    w_rd_acc    = !r_mm_busy_o && L2_read_request && !L2_write_request;
    w_full      = (r_count == CNT_W'(DEPTH)) && !w_deq;
    w_enq_new   = w_wr_acc && !w_co_hit && !w_full;
    w_enq_pend  = r_wr_pend && w_deq;
    w_enq       = w_enq_new || w_enq_pend;
    w_enq_addr  = r_wr_pend ? r_pend_addr : L2_word_address;
    w_enq_data  = r_wr_pend ? r_pend_data : L2_wdata;
  end

  // Address search: read hit (newest wins) and coalesce target (excludes in-flight head)
  always_comb begin
    logic [PTR_W-1:0] v_idx;
    w_rd_hit  = 1'b0;
    w_rd_data = '0;
    w_co_hit  = 1'b0;
    w_co_idx  = '0;
    v_idx     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      v_idx = r_head + PTR_W'(i);
      if ((CNT_W'(i) < r_count) && (r_addr[v_idx] == L2_word_address)) begin
        w_rd_hit  = 1'b1;
        w_rd_data = r_data[v_idx];
        if (!((i == 0) && w_hd_busy)) begin
          w_co_hit = 1'b1;
          w_co_idx = v_idx;
        end
      end
    end
  end

  // Entry storage; validity is tracked by head/count only
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_enq) begin
        r_addr[r_tail] <= w_enq_addr;
        r_data[r_tail] <= w_enq_data;
      end else if (w_wr_acc && w_co_hit) begin
        r_data[w_co_idx] <= L2_wdata;
      end
    end
  end

  // Memory-side FSM, upstream handshake and FIFO bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_wr_pend   <= 1'b0;
      r_rd_pend   <= 1'b0;
      r_hit       <= 1'b0;
      r_pend_addr <= '0;
      r_pend_data <= '0;
      r_hit_data  <= '0;
      r_l2_rdata  <= '0;
      r_mm_busy_o <= 1'b0;
      r_mm_rd_req <= 1'b0;
      r_mm_wr_req <= 1'b0;
      r_mm_addr   <= '0;
      r_mm_wdata  <= '0;
    end else begin
      r_mm_rd_req <= 1'b0;
      r_mm_wr_req <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_launch_rd) begin
            r_state     <= RD_ISSUE;
            r_mm_rd_req <= 1'b1;
            r_mm_addr   <= r_pend_addr;
          end else if (w_launch_wr) begin
            r_state     <= WR_ISSUE;
            r_mm_wr_req <= 1'b1;
            r_mm_addr   <= r_addr[r_head];
            r_mm_wdata  <= r_data[r_head];
          end
        end
        RD_ISSUE: r_state <= RD_ACK;
        RD_ACK:   if (mm_busy) r_state <= RD_DONE;
        RD_DONE: begin
          if (!mm_busy) begin
            r_state     <= IDLE;
            r_l2_rdata  <= mm_rdata;
            r_rd_pend   <= 1'b0;
            r_mm_busy_o <= 1'b0;
          end
        end
        WR_ISSUE: r_state <= WR_ACK;
        WR_ACK:   if (mm_busy) r_state <= WR_DONE;
        WR_DONE:  if (!mm_busy) r_state <= IDLE;
        default:  r_state <= IDLE;
      endcase

      // Buffer hit: one busy cycle, then present the captured entry data
      if (r_hit) begin
        r_hit       <= 1'b0;
        r_l2_rdata  <= r_hit_data;
        r_mm_busy_o <= 1'b0;
      end

      if (w_wr_acc && !w_co_hit && w_full) begin
        r_wr_pend   <= 1'b1;
        r_pend_addr <= L2_word_address;
        r_pend_data <= L2_wdata;
        r_mm_busy_o <= 1'b1;
      end else if (w_rd_acc) begin
        r_mm_busy_o <= 1'b1;
        if (w_rd_hit) begin
          r_hit      <= 1'b1;
          r_hit_data <= w_rd_data;
        end else begin
          r_rd_pend   <= 1'b1;
          r_pend_addr <= L2_word_address;
        end
      end

      // Stalled write lands in the slot freed by the head drain
      if (w_enq_pend) begin
        r_wr_pend   <= 1'b0;
        r_mm_busy_o <= 1'b0;
      end

      r_head  <= r_head + PTR_W'(w_deq);
      r_tail  <= r_tail + PTR_W'(w_enq);
      r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
    end
  end

  assign L2_rdata         = r_l2_rdata;
  assign MM_busy          = r_mm_busy_o;
  assign mm_read_request  = r_mm_rd_req;
  assign mm_write_request = r_mm_wr_req;
  assign mm_word_address  = r_mm_addr;
  assign mm_wdata         = r_mm_wdata;
  assign buf_empty        = (r_count == '0) && !w_in_wr;

endmodule

// File: tb/tb_l2_mm_write_buffer.sv
// Bench for l2_mm_write_buffer: directed scenarios plus a randomized phase.
// Reference: a flat "architectural memory" (last value written per address)
// that every L2 read must return and that main_memory must hold once drained.
module tb_l2_mm_write_buffer;
  localparam int unsigned N  = 32;
  localparam int unsigned AW = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          L2_read_request, L2_write_request;
  logic [AW-1:0] L2_word_address;
  logic [N-1:0]  L2_wdata, L2_rdata;
  logic          MM_busy, mm_read_request, mm_write_request, mm_busy, buf_empty;
  logic [AW-1:0] mm_word_address;
  logic [N-1:0]  mm_wdata;
  logic [N-1:0]  mm_rdata = '0;

  always #5 clk = ~clk;

  l2_mm_write_buffer #(.n(N), .ADDR_W(AW), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .L2_read_request(L2_read_request), .L2_write_request(L2_write_request),
    .L2_word_address(L2_word_address), .L2_wdata(L2_wdata), .L2_rdata(L2_rdata),
    .MM_busy(MM_busy), .mm_read_request(mm_read_request), .mm_write_request(mm_write_request),
    .mm_word_address(mm_word_address), .mm_wdata(mm_wdata), .mm_rdata(mm_rdata),
    .mm_busy(mm_busy), .buf_empty(buf_empty)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int a);
    return (a == 32'h40) ? 32'h1234_5678 : (32'hA500_0000 | 32'(a));
  endfunction

  // Main-memory model: busy rises the cycle after a request, stays high for the latency
  typedef struct { bit rd; logic [AW-1:0] a; logic [N-1:0] d; } mm_op_t;
  mm_op_t        log_q[$];
  int            n_req_cycles = 0;
  int            fixed_lat = 5;
  logic          stall = 1'b0;
  bit            m_busy = 1'b0;
  int            m_cnt = 0;
  bit            m_rd = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [N-1:0]  m_data = '0;
  bit [31:0]     mem [0:1023];
  bit            wrt [0:1023];

  assign mm_busy = m_busy | stall;

  function automatic logic [31:0] mm_val(input logic [AW-1:0] a);
    return wrt[a[9:0]] ? mem[a[9:0]] : pat(int'(a[9:0]));
  endfunction

  always @(posedge clk) begin
    if (mm_read_request || mm_write_request) n_req_cycles <= n_req_cycles + 1;
    if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_busy <= 1'b0;
        if (m_rd) mm_rdata <= mm_val(m_addr);
        else begin
          mem[m_addr[9:0]] <= m_data;
          wrt[m_addr[9:0]] <= 1'b1;
        end
      end
    end else if ((mm_read_request || mm_write_request) && !mm_busy) begin
      m_busy <= 1'b1;
      m_cnt  <= (fixed_lat != 0) ? fixed_lat : int'($urandom_range(6, 1));
      m_rd   <= mm_read_request;
      m_addr <= mm_word_address;
      m_data <= mm_wdata;
      log_q.push_back('{rd: mm_read_request, a: mm_word_address, d: mm_wdata});
    end
  end

  logic [31:0] gold [0:1023];

  task automatic wait_ready();
    int k = 0;
    while (MM_busy && k < 500) begin @(negedge clk); k++; end
    if (MM_busy) chk("ready_timeout", 32'(MM_busy), 32'd0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [N-1:0] d, output bit busy_after);
    wait_ready();
    L2_write_request = 1'b1; L2_word_address = a; L2_wdata = d;
    gold[a[9:0]] = d;
    @(negedge clk);
    L2_write_request = 1'b0;
    busy_after = MM_busy;
  endtask

  task automatic rd(input logic [AW-1:0] a, output int bc);
    wait_ready();
    L2_read_request = 1'b1; L2_word_address = a;
    @(negedge clk);
    L2_read_request = 1'b0;
    bc = 0;
    while (MM_busy && bc < 500) begin bc++; @(negedge clk); end
    chk("rd_busy_seen", 32'(bc != 0), 32'd1);
    chk("rd_data", L2_rdata, gold[a[9:0]]);
  endtask

  task automatic wait_empty();
    int k = 0;
    while (!(buf_empty && !mm_busy) && k < 1000) begin @(negedge clk); k++; end
    chk("drain_done", 32'(buf_empty && !mm_busy), 32'd1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit b, saw;
    int bc, base, rq;
    bit [4:0] bz;
    for (int i = 0; i < 1024; i++) gold[i] = pat(i);
    reset = 1'b1; L2_read_request = 1'b0; L2_write_request = 1'b0;
    L2_word_address = '0; L2_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_MM_busy", 32'(MM_busy), 32'd0);
    chk("rst_buf_empty", 32'(buf_empty), 32'd1);
    chk("rst_mm_req", 32'({mm_read_request, mm_write_request}), 32'd0);
    chk("rst_L2_rdata", L2_rdata, 32'd0);
    chk("rst_mm_addr", 32'(mm_word_address), 32'd0);
    chk("rst_mm_wdata", mm_wdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: single posted write, zero stall, drains with latency 5
    fixed_lat = 5; base = log_q.size(); rq = n_req_cycles;
    wr(15'h0010, 32'hDEAD_BEEF, b);
    saw = b;
    for (int i = 0; i < 30; i++) begin @(negedge clk); saw |= MM_busy; end
    chk("t1_no_stall", 32'(saw), 32'd0);
    chk("t1_buf_empty", 32'(buf_empty), 32'd1);
    chk("t1_n_ops", 32'(log_q.size() - base), 32'd1);
    chk("t1_req_cycles", 32'(n_req_cycles - rq), 32'd1);
    chk("t1_addr", 32'(log_q[base].a), 32'h10);
    chk("t1_data", log_q[base].d, 32'hDEAD_BEEF);

    // 2: read hit before drain
    stall = 1'b1; rq = n_req_cycles;
    wr(15'h0020, 32'h1, b);
    rd(15'h0020, bc);
    chk("t2_busy_cycles", 32'(bc), 32'd1);
    chk("t2_rdata", L2_rdata, 32'h1);
    chk("t2_no_mm_req", 32'(n_req_cycles - rq), 32'd0);
    stall = 1'b0;
    wait_empty();

    // 3: coalescing while memory is stalled
    stall = 1'b1; base = log_q.size();
    wr(15'h0030, 32'hA, b);
    wr(15'h0030, 32'hB, b);
    chk("t3_no_stall", 32'(b), 32'd0);
    repeat (3) @(negedge clk);
    stall = 1'b0;
    wait_empty();
    chk("t3_n_ops", 32'(log_q.size() - base), 32'd1);
    chk("t3_data", log_q[base].d, 32'hB);

    // 4: five distinct writes overflow a 4-deep buffer
    fixed_lat = 8; base = log_q.size();
    for (int i = 0; i < 5; i++) begin
      wr(AW'(32'h100 + i), 32'hC0DE_0000 + 32'(i), b);
      bz[i] = b;
    end
    chk("t4_busy_pattern", 32'(bz), 32'b10000);
    wait_empty();
    chk("t4_n_ops", 32'(log_q.size() - base), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk("t4_order_addr", 32'(log_q[base + i].a), 32'h100 + 32'(i));
      chk("t4_order_data", log_q[base + i].d, 32'hC0DE_0000 + 32'(i));
    end

    // 5: read miss behind an in-flight drain
    fixed_lat = 6; base = log_q.size();
    wr(15'h0050, 32'h5050_5050, b);
    wr(15'h0051, 32'h5151_5151, b);
    rd(15'h0040, bc);
    chk("t5_rdata", L2_rdata, 32'h1234_5678);
    wait_empty();
    chk("t5_n_ops", 32'(log_q.size() - base), 32'd3);
    chk("t5_op0", {log_q[base].rd, 15'd0, 1'b0, log_q[base].a}, {1'b0, 15'd0, 1'b0, 15'h50});
    chk("t5_op1", {log_q[base+1].rd, 15'd0, 1'b0, log_q[base+1].a}, {1'b1, 15'd0, 1'b0, 15'h40});
    chk("t5_op2", {log_q[base+2].rd, 15'd0, 1'b0, log_q[base+2].a}, {1'b0, 15'd0, 1'b0, 15'h51});

    // 6: reset while waiting for a drain to finish, three entries buffered
    stall = 1'b1;
    wr(15'h0060, 32'h6, b);
    wr(15'h0061, 32'h7, b);
    wr(15'h0062, 32'h8, b);
    stall = 1'b0;
    bc = 0;
    while (!mm_write_request && bc < 50) begin @(negedge clk); bc++; end
    chk("t6_drain_started", 32'(mm_write_request), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_MM_busy", 32'(MM_busy), 32'd0);
    chk("t6_buf_empty", 32'(buf_empty), 32'd1);
    chk("t6_mm_req", 32'({mm_read_request, mm_write_request}), 32'd0);
    chk("t6_mm_addr", 32'(mm_word_address), 32'd0);
    chk("t6_mm_wdata", mm_wdata, 32'd0);
    chk("t6_L2_rdata", L2_rdata, 32'd0);
    reset = 1'b0;
    rq = n_req_cycles;
    repeat (40) @(negedge clk);
    chk("t6_no_more_req", 32'(n_req_cycles - rq), 32'd0);
    chk("t6_still_empty", 32'(buf_empty), 32'd1);

    // Random mix over a small address window to exercise hits, coalescing and overflow
    fixed_lat = 0;
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [AW-1:0] a;
      r = int'($urandom_range(9, 0));
      a = AW'(32'h200 + $urandom_range(7, 0));
      if (r < 5) wr(a, $urandom, b);
      else if (r < 8) rd(a, bc);
      else repeat (int'($urandom_range(4, 1))) @(negedge clk);
    end
    wait_empty();
    for (int i = 0; i < 8; i++)
      chk("rand_final_mem", mm_val(AW'(32'h200 + i)), gold[32'h200 + i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
